// File: rtl/tl_phase_arbiter.sv
// tl_phase_arbiter: four-phase traffic light arbiter (A-straight, A-left,
// B-straight, B-left) with a round-robin pick among level-sampled sensor
// requests, min/max green dwell, and yellow and all-red clearance.
// Optional macro TL_PED_PHASE_EN adds a pedestrian phase (ped_req/walk, PED_T)
// that is served as round-robin index 4.
module tl_phase_arbiter #(
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 12,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1
`ifdef TL_PED_PHASE_EN
  , parameter int PED_T   = 3
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Ta,
  input  logic       Tal,
  input  logic       Tb,
  input  logic       Tbl,
`ifdef TL_PED_PHASE_EN
  input  logic       ped_req,
  output logic       walk,
`endif
  output logic [1:0] La,
  output logic [1:0] Lb,
  output logic [3:0] grant,
  output logic       busy
);

  localparam logic [1:0] LT_GREEN  = 2'b00;
  localparam logic [1:0] LT_YELLOW = 2'b01;
  localparam logic [1:0] LT_RED    = 2'b10;
  localparam logic [1:0] LT_LEFT   = 2'b11;

`ifdef TL_PED_PHASE_EN
  localparam int NREQ    = 5;
  localparam int PED_LEN = PED_T;
`else
  localparam int NREQ    = 4;
  localparam int PED_LEN = 1;
`endif

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  localparam int CNT_TOP = max4(MAX_GREEN, YELLOW_T, ALLRED_T, PED_LEN);
  localparam int CW      = $clog2(CNT_TOP + 1);

  // Terminal counts: the counter holds (cycles spent in state - 1).
  localparam logic [CW-1:0] MIN_LAST = CW'(MIN_GREEN - 1);
  localparam logic [CW-1:0] MAX_LAST = CW'(MAX_GREEN - 1);
  localparam logic [CW-1:0] MAX_SAT  = CW'(MAX_GREEN);
  localparam logic [CW-1:0] YEL_LAST = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] AR_LAST  = CW'(ALLRED_T - 1);
`ifdef TL_PED_PHASE_EN
  localparam logic [CW-1:0] PED_LAST = CW'(PED_T - 1);
`endif

  typedef enum logic [2:0] {IDLE, GREEN, YELLOW, ALLRED, PED} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    last;     // last granted index, also the phase being served

  // Requests padded to 8 bits so a 3-bit index never overruns the vector.
  logic [7:0] req_v;
  logic [2:0] pick, idx;
  logic       any_req, others, arb_now, leave_green;
  logic [1:0] g_la, g_lb;
  logic [3:0] g_grant;

  // Gather requests into one indexed vector.
  always_comb begin
    req_v = {4'b0, Tbl, Tb, Tal, Ta};
`ifdef TL_PED_PHASE_EN
    req_v[4] = ped_req;
`endif
  end

  // Round-robin search from last+1; the lowest offset hit wins, so the
  // previously granted phase is only picked again when nothing else asks.
  always_comb begin
    pick    = last;
    idx     = '0;
    any_req = |req_v;
    for (int off = NREQ; off >= 1; off--) begin
      idx = 3'((int'(last) + off) % NREQ);
      if (req_v[idx]) pick = idx;
    end
  end

  // Green exit decision and the light pattern of the phase about to start.
  always_comb begin
    others      = |(req_v & ~(8'b1 << last));
    arb_now     = (state == IDLE) || (state == ALLRED && cnt >= AR_LAST);
    leave_green = (cnt >= MIN_LAST) && (!req_v[last] || (cnt >= MAX_LAST && others));
    g_la    = LT_RED;
    g_lb    = LT_RED;
    g_grant = '0;
    case (pick)
      3'd0:    g_la = LT_GREEN;
      3'd1:    g_la = LT_LEFT;
      3'd2:    g_lb = LT_GREEN;
      3'd3:    g_lb = LT_LEFT;
      default: ;
    endcase
    if (pick < 3'd4) g_grant = 4'b1 << pick[1:0];
  end

  // Phase FSM; lights, grant and busy are registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 3'd3;
      La    <= LT_RED;
      Lb    <= LT_RED;
      grant <= '0;
      busy  <= 1'b0;
`ifdef TL_PED_PHASE_EN
      walk  <= 1'b0;
`endif
    end else if (arb_now) begin
      cnt <= '0;
      if (any_req) begin
        last  <= pick;
        La    <= g_la;
        Lb    <= g_lb;
        grant <= g_grant;
        busy  <= 1'b1;
`ifdef TL_PED_PHASE_EN
        state <= (pick == 3'd4) ? PED : GREEN;
        walk  <= (pick == 3'd4);
`else
        state <= GREEN;
`endif
      end else begin
        state <= IDLE;
        La    <= LT_RED;
        Lb    <= LT_RED;
        grant <= '0;
        busy  <= 1'b0;
      end
    end else begin
      case (state)
        GREEN: begin
          if (leave_green) begin
            state <= YELLOW;
            cnt   <= '0;
            La    <= (last < 3'd2) ? LT_YELLOW : LT_RED;
            Lb    <= (last < 3'd2) ? LT_RED : LT_YELLOW;
          end else if (cnt != MAX_SAT) begin
            cnt <= cnt + 1'b1;
          end
        end
        YELLOW: begin
          if (cnt >= YEL_LAST) begin
            state <= ALLRED;
            cnt   <= '0;
            La    <= LT_RED;
            Lb    <= LT_RED;
            grant <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef TL_PED_PHASE_EN
        PED: begin
          if (cnt >= PED_LAST) begin
            state <= ALLRED;
            cnt   <= '0;
            walk  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        ALLRED:  cnt <= cnt + 1'b1;
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tl_phase_arbiter.sv
// Directed bench for tl_phase_arbiter with default parameters
// (MIN_GREEN=4, MAX_GREEN=12, YELLOW_T=2, ALLRED_T=1).
module tb_tl_phase_arbiter;

  localparam logic [1:0] GRN = 2'b00, YEL = 2'b01, RED = 2'b10, LFT = 2'b11;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Ta = 0, Tal = 0, Tb = 0, Tbl = 0;
  logic [1:0] La, Lb;
  logic [3:0] grant;
  logic       busy;
`ifdef TL_PED_PHASE_EN
  logic       ped_req = 0;
  logic       walk;
`endif

  int checks = 0;
  int errors = 0;

  tl_phase_arbiter dut (
    .clk(clk), .reset(reset),
    .Ta(Ta), .Tal(Tal), .Tb(Tb), .Tbl(Tbl),
`ifdef TL_PED_PHASE_EN
    .ped_req(ped_req), .walk(walk),
`endif
    .La(La), .Lb(Lb), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges with the given requests, release after an edge.
  task automatic do_reset(input logic [3:0] r);
    reset = 1'b1;
    {Tbl, Tb, Tal, Ta} = r;
    step(2);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset(4'b0001);
    checks++;
    if ({La, Lb, grant, busy} !== {RED, RED, 4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: La=%b Lb=%b grant=%b busy=%b, want La=10 Lb=10 grant=0000 busy=0", La, Lb, grant, busy);
    end
  endtask

  // Ta alone: green on the first edge after release and then rests.
  task automatic test_rest_green;
    step(1);
    checks++;
    if ({grant, La, Lb, busy} !== {4'b0001, GRN, RED, 1'b1}) begin
      errors++;
      $display("FAIL first_grant: grant=%b La=%b Lb=%b busy=%b, want 0001 00 10 1", grant, La, Lb, busy);
    end
    for (int i = 0; i < 22; i++) begin
      step(1);
      checks++;
      if ({grant, La} !== {4'b0001, GRN}) begin
        errors++;
        $display("FAIL rest_green[%0d]: grant=%b La=%b, want 0001 00", i, grant, La);
      end
    end
  endtask

  // Tal for two cycles: 4 LEFT, 2 YELLOW, 1 ALLRED, then IDLE.
  task automatic test_left_min;
    logic [1:0] exp_la [0:7];
    logic [3:0] exp_g  [0:7];
    logic       exp_b  [0:7];
    exp_la = '{LFT, LFT, LFT, LFT, YEL, YEL, RED, RED};
    exp_g  = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
    exp_b  = '{1, 1, 1, 1, 1, 1, 1, 0};
    do_reset(4'b0010);
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (i == 1) Tal = 1'b0;
      checks++;
      if ({La, Lb, grant, busy} !== {exp_la[i], RED, exp_g[i], exp_b[i]}) begin
        errors++;
        $display("FAIL left_min[%0d]: La=%b Lb=%b grant=%b busy=%b, want %b 10 %b %b",
                 i, La, Lb, grant, busy, exp_la[i], exp_g[i], exp_b[i]);
      end
    end
  endtask

  // All four requests held: 12 green, 2 yellow, 1 all-red per phase.
  task automatic test_round_robin;
    logic [3:0] seq [0:4];
    logic [3:0] eg;
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset(4'b1111);
    for (int p = 0; p < 5; p++) begin
      for (int c = 0; c < 15; c++) begin
        step(1);
        eg = (c < 14) ? seq[p] : 4'b0000;
        checks++;
        if (grant !== eg) begin
          errors++;
          $display("FAIL rr_grant[p%0d c%0d]: grant=%b, want %b", p, c, grant, eg);
        end
        if (c == 12) begin
          checks++;
          if ((seq[p][1:0] != 2'b00 ? La : Lb) !== YEL) begin
            errors++;
            $display("FAIL rr_yellow[p%0d]: La=%b Lb=%b, want yellow on granted street", p, La, Lb);
          end
        end
        if (p == 4 && c == 0) break;
      end
    end
    {Tbl, Tb, Tal, Ta} = 4'b0000;
  endtask

  // Ta resting; Tb raised after green cycle 6 -> yellow after cycle 12.
  task automatic test_max_green;
    do_reset(4'b0001);
    for (int c = 1; c <= 16; c++) begin
      step(1);
      if (c == 6) Tb = 1'b1;
      if (c <= 12) begin
        checks++;
        if (La !== GRN) begin
          errors++;
          $display("FAIL max_green_hold[%0d]: La=%b, want 00", c, La);
        end
      end
      if (c == 13) begin
        checks++;
        if ({La, Lb} !== {YEL, RED}) begin
          errors++;
          $display("FAIL max_green_yellow: La=%b Lb=%b, want 01 10", La, Lb);
        end
      end
      if (c == 16) begin
        checks++;
        if ({La, Lb, grant} !== {RED, GRN, 4'b0100}) begin
          errors++;
          $display("FAIL max_green_b: La=%b Lb=%b grant=%b, want 10 00 0100", La, Lb, grant);
        end
      end
    end
    {Tbl, Tb, Tal, Ta} = 4'b0000;
  endtask

  // Reset during yellow clears lights at once; Tb served first afterwards.
  task automatic test_reset_mid_yellow;
    do_reset(4'b0001);
    step(1);
    Ta = 1'b0;
    step(4);
    checks++;
    if (La !== YEL) begin
      errors++;
      $display("FAIL pre_reset_yellow: La=%b, want 01", La);
    end
    Tb = 1'b1;
    reset = 1'b1;
    #1;
    checks++;
    if ({La, Lb, grant, busy} !== {RED, RED, 4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: La=%b Lb=%b grant=%b busy=%b, want 10 10 0000 0", La, Lb, grant, busy);
    end
    step(1);
    reset = 1'b0;
    step(1);
    checks++;
    if ({grant, Lb, La} !== {4'b0100, GRN, RED}) begin
      errors++;
      $display("FAIL post_reset_grant: grant=%b Lb=%b La=%b, want 0100 00 10", grant, Lb, La);
    end
    Tb = 1'b0;
  endtask

`ifdef TL_PED_PHASE_EN
  // Phase 0 first, then the pedestrian phase with walk for 3 cycles.
  task automatic test_ped;
    ped_req = 1'b1;
    do_reset(4'b0001);
    step(1);
    Ta = 1'b0;
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL ped_first: grant=%b, want 0001", grant);
    end
    step(6);
    for (int c = 0; c < 4; c++) begin
      step(1);
      if (c == 0) ped_req = 1'b0;
      checks++;
      if ({walk, La, Lb, grant} !== {(c < 3), RED, RED, 4'b0000}) begin
        errors++;
        $display("FAIL ped_walk[%0d]: walk=%b La=%b Lb=%b grant=%b", c, walk, La, Lb, grant);
      end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_rest_green;
    test_left_min;
    test_round_robin;
    test_max_green;
    test_reset_mid_yellow;
`ifdef TL_PED_PHASE_EN
    test_ped;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
